alu_control_seq: RTL and testbench

Registered, parametrised ALU control unit for the multi-cycle datapath. It decodes a 3-bit ALU-op class and the full 6-bit R-type funct field into a 4-bit ALU control code, one cycle after a valid/ready handshake. It also sequences iterative multiply/divide operations: it holds the issue stage stalled for a programmable number of cycles and pulses the HI/LO write enable on completion. It sits between the main control FSM and the ALU / mult-div unit.

---
 rtl/alu_control_seq.sv | 117 +++++++++++
 tb/tb_alu_control_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_seq.sv
// ALU control decoder with registered output and an iterative mult/div sequencer.
// Decodes alu_op/funct into an ALU control code and stalls issue while a mult/div runs.
module alu_control_seq #(
    parameter int MULDIV_CYCLES = 32,
    parameter int CTRL_W        = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic              flush,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              ctrl_valid,
    output logic              illegal,
    output logic              busy,
    output logic [1:0]        muldiv_op,
    output logic              hilo_we
);

    localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

    typedef enum logic {IDLE, MULDIV} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [3:0]         code;
    logic               bad;
    logic               is_md;
    logic               accept;

    assign busy     = (state == MULDIV);
    assign in_ready = !busy;
    assign accept   = in_valid & in_ready & !flush;
    assign hilo_we  = busy & (cnt == '0) & !flush;

    always_comb begin
        code  = 4'd15;
        bad   = 1'b0;
        is_md = 1'b0;
        case (alu_op)
            3'b000, 3'b011: code = 4'd2;
            3'b001:         code = 4'd6;
            3'b100:         code = 4'd0;
            3'b101:         code = 4'd1;
            3'b110:         code = 4'd7;
            3'b111:         code = 4'd14;
            default: begin
                casez (funct)
                    6'b100000, 6'b100001: code = 4'd2;
                    6'b100010, 6'b100011: code = 4'd6;
                    6'b100100:            code = 4'd0;
                    6'b100101:            code = 4'd1;
                    6'b100110:            code = 4'd13;
                    6'b100111:            code = 4'd12;
                    6'b101010:            code = 4'd7;
                    6'b101011:            code = 4'd8;
                    6'b000000:            code = 4'd3;
                    6'b000010:            code = 4'd4;
                    6'b000011:            code = 4'd5;
                    6'b0110??: begin
                        code  = 4'd9;
                        is_md = 1'b1;
                    end
                    default: begin
                        code = 4'd15;
                        bad  = 1'b1;
                    end
                endcase
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept && is_md) begin
                    state_nxt = MULDIV;
                    cnt_nxt   = CNT_W'(MULDIV_CYCLES - 1);
                end
            end
            default: begin
                // flush abandons the op; cnt==0 is the completion cycle
                if (flush || cnt == '0) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            ctrl_out   <= '0;
            ctrl_valid <= 1'b0;
            illegal    <= 1'b0;
            muldiv_op  <= 2'b00;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            ctrl_valid <= accept;
            if (accept) begin
                ctrl_out <= CTRL_W'(code);
                illegal  <= bad;
                if (is_md) muldiv_op <= funct[1:0];
            end
        end
    end

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed bench for alu_control_seq: three instances cover MULDIV_CYCLES 4, 8 and 1 (CTRL_W=6).
module tb_alu_control_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] alu_op;
    logic [5:0] funct;
    logic       flush;

    logic       a_in_ready, a_ctrl_valid, a_illegal, a_busy, a_hilo_we;
    logic [3:0] a_ctrl_out;
    logic [1:0] a_muldiv_op;
    logic       b_in_ready, b_ctrl_valid, b_illegal, b_busy, b_hilo_we;
    logic [3:0] b_ctrl_out;
    logic [1:0] b_muldiv_op;
    logic       c_in_ready, c_ctrl_valid, c_illegal, c_busy, c_hilo_we;
    logic [5:0] c_ctrl_out;
    logic [1:0] c_muldiv_op;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    alu_control_seq #(.MULDIV_CYCLES(4), .CTRL_W(4)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .alu_op(alu_op), .funct(funct), .flush(flush), .ctrl_out(a_ctrl_out),
        .ctrl_valid(a_ctrl_valid), .illegal(a_illegal), .busy(a_busy),
        .muldiv_op(a_muldiv_op), .hilo_we(a_hilo_we));

    alu_control_seq #(.MULDIV_CYCLES(8), .CTRL_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .alu_op(alu_op), .funct(funct), .flush(flush), .ctrl_out(b_ctrl_out),
        .ctrl_valid(b_ctrl_valid), .illegal(b_illegal), .busy(b_busy),
        .muldiv_op(b_muldiv_op), .hilo_we(b_hilo_we));

    alu_control_seq #(.MULDIV_CYCLES(1), .CTRL_W(6)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
        .alu_op(alu_op), .funct(funct), .flush(flush), .ctrl_out(c_ctrl_out),
        .ctrl_valid(c_ctrl_valid), .illegal(c_illegal), .busy(c_busy),
        .muldiv_op(c_muldiv_op), .hilo_we(c_hilo_we));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        alu_op   = 3'b000;
        funct    = 6'b000000;
        flush    = 1'b0;
        #12;
        chk("rst_ctrl_out",   32'(a_ctrl_out), 0);
        chk("rst_ctrl_valid", 32'(a_ctrl_valid), 0);
        chk("rst_illegal",    32'(a_illegal), 0);
        chk("rst_busy",       32'(a_busy), 0);
        chk("rst_in_ready",   32'(a_in_ready), 1);
        chk("rst_muldiv_op",  32'(a_muldiv_op), 0);
        chk("rst_hilo_we",    32'(a_hilo_we), 0);
        rst_n = 1'b1;

        // back-to-back single-cycle ops
        in_valid = 1'b1; alu_op = 3'b010; funct = 6'b100010;
        step();
        chk("b2b_sub",   32'(a_ctrl_out), 6);
        chk("b2b_v0",    32'(a_ctrl_valid), 1);
        funct = 6'b100111;
        step();
        chk("b2b_nor",   32'(a_ctrl_out), 12);
        chk("b2b_v1",    32'(a_ctrl_valid), 1);
        funct = 6'b101011;
        step();
        chk("b2b_sltu",  32'(a_ctrl_out), 8);
        chk("b2b_v2",    32'(a_ctrl_valid), 1);
        alu_op = 3'b111; funct = 6'b000000;
        step();
        chk("b2b_lui",   32'(a_ctrl_out), 14);
        chk("b2b_v3",    32'(a_ctrl_valid), 1);
        in_valid = 1'b0;
        step();
        chk("hold_out",  32'(a_ctrl_out), 14);
        chk("hold_v",    32'(a_ctrl_valid), 0);

        // a few more decode points
        in_valid = 1'b1; alu_op = 3'b010; funct = 6'b100110;
        step();
        chk("dec_xor",   32'(a_ctrl_out), 13);
        funct = 6'b000011;
        step();
        chk("dec_sra",   32'(a_ctrl_out), 5);
        alu_op = 3'b001;
        step();
        chk("dec_beq",   32'(a_ctrl_out), 6);
        alu_op = 3'b110;
        step();
        chk("dec_slti",  32'(a_ctrl_out), 7);

        // illegal funct
        alu_op = 3'b010; funct = 6'b111111;
        step();
        chk("ill_code",  32'(a_ctrl_out), 15);
        chk("ill_flag",  32'(a_illegal), 1);
        chk("ill_busy",  32'(a_busy), 0);
        chk("ill_valid", 32'(a_ctrl_valid), 1);
        alu_op = 3'b000;
        step();
        chk("ill_clr_code", 32'(a_ctrl_out), 2);
        chk("ill_clr_flag", 32'(a_illegal), 0);

        // flush with valid in IDLE: no accept
        alu_op = 3'b001; flush = 1'b1;
        step();
        chk("iflush_valid", 32'(a_ctrl_valid), 0);
        chk("iflush_hold",  32'(a_ctrl_out), 2);
        flush = 1'b0; in_valid = 1'b0;

        // MULDIV_CYCLES=4: div accepted at edge N, second op held from N+1
        in_valid = 1'b1; alu_op = 3'b010; funct = 6'b011010;
        step();
        chk("md4_code",  32'(a_ctrl_out), 9);
        chk("md4_op",    32'(a_muldiv_op), 2);
        chk("md4_busy1", 32'(a_busy), 1);
        chk("md4_rdy1",  32'(a_in_ready), 0);
        chk("md4_we1",   32'(a_hilo_we), 0);
        alu_op = 3'b101;
        step();
        chk("md4_busy2", 32'(a_busy), 1);
        chk("md4_we2",   32'(a_hilo_we), 0);
        chk("md4_v2",    32'(a_ctrl_valid), 0);
        chk("md4_hold2", 32'(a_ctrl_out), 9);
        step();
        chk("md4_busy3", 32'(a_busy), 1);
        chk("md4_we3",   32'(a_hilo_we), 0);
        step();
        chk("md4_busy4", 32'(a_busy), 1);
        chk("md4_we4",   32'(a_hilo_we), 1);
        chk("md4_rdy4",  32'(a_in_ready), 0);
        step();
        chk("md4_busy5", 32'(a_busy), 0);
        chk("md4_we5",   32'(a_hilo_we), 0);
        chk("md4_rdy5",  32'(a_in_ready), 1);
        chk("md4_v5",    32'(a_ctrl_valid), 0);
        chk("md4_hold5", 32'(a_ctrl_out), 9);
        step();
        chk("md4_next",  32'(a_ctrl_out), 1);
        chk("md4_nextv", 32'(a_ctrl_valid), 1);
        in_valid = 1'b0;

        // MULDIV_CYCLES=1, CTRL_W=6: multu
        pulse_reset();
        in_valid = 1'b1; alu_op = 3'b010; funct = 6'b011001;
        step();
        chk("md1_busy",  32'(c_busy), 1);
        chk("md1_we",    32'(c_hilo_we), 1);
        chk("md1_code",  32'(c_ctrl_out), 9);
        chk("md1_op",    32'(c_muldiv_op), 1);
        in_valid = 1'b0;
        step();
        chk("md1_busy2", 32'(c_busy), 0);
        chk("md1_we2",   32'(c_hilo_we), 0);
        chk("md1_rdy2",  32'(c_in_ready), 1);

        // MULDIV_CYCLES=8: flush at cnt=2
        pulse_reset();
        in_valid = 1'b1; alu_op = 3'b010; funct = 6'b011000;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("fl_busy", 32'(b_busy), 1);
            chk("fl_we",   32'(b_hilo_we), 0);
        end
        flush = 1'b1;
        #1;
        chk("fl_we_flush", 32'(b_hilo_we), 0);
        step();
        chk("fl_idle",   32'(b_busy), 0);
        chk("fl_rdy",    32'(b_in_ready), 1);
        chk("fl_we_post", 32'(b_hilo_we), 0);
        flush = 1'b0; in_valid = 1'b1; alu_op = 3'b000;
        step();
        chk("fl_add",    32'(b_ctrl_out), 2);
        chk("fl_addv",   32'(b_ctrl_valid), 1);
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("fl_no_we", 32'(b_hilo_we), 0);
        end

        // reset mid-MULDIV at cnt=5 (MULDIV_CYCLES=8)
        pulse_reset();
        in_valid = 1'b1; alu_op = 3'b010; funct = 6'b011010;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("mr_busy_pre", 32'(b_busy), 1);
        chk("mr_op_pre",   32'(b_muldiv_op), 2);
        rst_n = 1'b0;
        #1;
        chk("mr_ctrl_out", 32'(b_ctrl_out), 0);
        chk("mr_valid",    32'(b_ctrl_valid), 0);
        chk("mr_illegal",  32'(b_illegal), 0);
        chk("mr_busy",     32'(b_busy), 0);
        chk("mr_rdy",      32'(b_in_ready), 1);
        chk("mr_op",       32'(b_muldiv_op), 0);
        chk("mr_we",       32'(b_hilo_we), 0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("mr_post_we",   32'(b_hilo_we), 0);
            chk("mr_post_busy", 32'(b_busy), 0);
            chk("mr_post_rdy",  32'(b_in_ready), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
